// File: rtl/vehicle_sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module : vehicle_sensor_conditioner_if
// Brief  : Sensor-in / demand-out bundle of the loop-detector conditioner.
// Rev    : 1.0  initial release
// ============================================================================
interface vehicle_sensor_conditioner_if;
  logic       sensor_raw;
  logic       count_clr;
  logic       vehicle;
  logic       sensor_fault;
  logic [7:0] vehicle_count;

  modport master (
    output sensor_raw,
    output count_clr,
    input  vehicle,
    input  sensor_fault,
    input  vehicle_count
  );

  modport slave (
    input  sensor_raw,
    input  count_clr,
    output vehicle,
    output sensor_fault,
    output vehicle_count
  );
endinterface
`default_nettype wire

// File: rtl/vehicle_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module : vehicle_sensor_conditioner
// Brief  : Synchronise, debounce and hold the loop contact; flag stuck-on.
// Rev    : 1.0  initial release
// ============================================================================
module vehicle_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 32,
  parameter int CNT_W           = 16
) (
  input  logic                          clock,
  input  logic                          clear,
  vehicle_sensor_conditioner_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_deb_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stuck_last = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUAL_ON  = 3'd1,
    ST_PRESENT  = 3'd2,
    ST_QUAL_OFF = 3'd3,
    ST_HOLD     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  logic             r_s1, r_s2;
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_dcnt, w_dcnt;
  logic [CNT_W-1:0] r_hcnt, w_hcnt;
  logic [CNT_W-1:0] r_scnt, w_scnt;
  logic             r_vehicle, w_vehicle;
  logic             r_fault, w_fault;
  logic [7:0]       r_count;
  logic             w_inc;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= ST_IDLE;
      r_dcnt    <= '0;
      r_hcnt    <= '0;
      r_scnt    <= '0;
      r_vehicle <= 1'b0;
      r_fault   <= 1'b0;
      r_count   <= 8'd0;
    end else begin
      r_s1      <= bus.sensor_raw;
      r_s2      <= r_s1;
      r_state   <= w_state;
      r_dcnt    <= w_dcnt;
      r_hcnt    <= w_hcnt;
      r_scnt    <= w_scnt;
      r_vehicle <= w_vehicle;
      r_fault   <= w_fault;
      // A clear in the same cycle as an arrival wins.
      if (bus.count_clr) begin
        r_count <= 8'd0;
      end else if (w_inc && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_state   = r_state;
    w_dcnt    = r_dcnt;
    w_hcnt    = r_hcnt;
    w_scnt    = r_scnt;
    w_vehicle = r_vehicle;
    w_fault   = r_fault;
    w_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_vehicle = 1'b0;
        if (r_s2) begin
          w_state = ST_QUAL_ON;
          w_dcnt  = c_one;
        end
      end
      ST_QUAL_ON: begin
        if (!r_s2) begin
          if (r_vehicle) begin
            w_state = ST_HOLD;
            w_hcnt  = '0;
          end else begin
            w_state = ST_IDLE;
          end
        end else if (r_dcnt == c_deb_last) begin
          w_state   = ST_PRESENT;
          w_vehicle = 1'b1;
          w_scnt    = '0;
          w_inc     = 1'b1;
        end else begin
          w_dcnt = r_dcnt + c_one;
        end
      end
      ST_PRESENT, ST_QUAL_OFF: begin
        w_scnt = r_scnt + c_one;
        // Stuck detection outranks any release in progress.
        if (r_scnt == c_stuck_last) begin
          w_state   = ST_FAULT;
          w_fault   = 1'b1;
          w_vehicle = 1'b1;
          w_dcnt    = '0;
        end else if (r_state == ST_PRESENT) begin
          if (!r_s2) begin
            w_state = ST_QUAL_OFF;
            w_dcnt  = c_one;
          end
        end else if (r_s2) begin
          w_state = ST_PRESENT;
        end else if (r_dcnt == c_deb_last) begin
          w_state = ST_HOLD;
          w_hcnt  = '0;
        end else begin
          w_dcnt = r_dcnt + c_one;
        end
      end
      ST_HOLD: begin
        w_vehicle = 1'b1;
        w_hcnt    = r_hcnt + c_one;
        if (r_s2) begin
          w_state = ST_QUAL_ON;
          w_dcnt  = c_one;
        end else if (r_hcnt == c_hold_last) begin
          w_state   = ST_IDLE;
          w_vehicle = 1'b0;
        end
      end
      ST_FAULT: begin
        // Fail-safe: keep demanding until the contact is clearly released.
        w_vehicle = 1'b1;
        w_fault   = 1'b1;
        if (r_s2) begin
          w_dcnt = '0;
        end else if (r_dcnt == c_deb_last) begin
          w_state   = ST_IDLE;
          w_vehicle = 1'b0;
          w_fault   = 1'b0;
          w_dcnt    = '0;
        end else begin
          w_dcnt = r_dcnt + c_one;
        end
      end
      default: begin
        w_state   = ST_IDLE;
        w_vehicle = 1'b0;
        w_fault   = 1'b0;
      end
    endcase
  end

  assign bus.vehicle       = r_vehicle;
  assign bus.sensor_fault  = r_fault;
  assign bus.vehicle_count = r_count;

endmodule
`default_nettype wire
